// File: rtl/ib_uart_bridge.sv
// ib_uart_bridge: byte bridge between the UART core and the IB I/O-expander.
// Host bytes are queued and offered to the meter over a four-phase handshake.
// Meter bytes are captured into a second queue and drained to UART TX.
`timescale 1ns/1ps
module ib_uart_bridge #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_valid,
  output logic       uart_rx_overrun,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  output logic [7:0] ib_tx_data,
  output logic       ib_tx_data_avail,
  input  logic       ib_tx_data_ack_n,
  input  logic [7:0] ib_rx_data,
  input  logic       ib_rx_data_avail,
  output logic       ib_tx_ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

  localparam logic [1:0] D_IDLE    = 2'd0;
  localparam logic [1:0] D_OFFER   = 2'd1;
  localparam logic [1:0] D_RELEASE = 2'd2;
  localparam logic [0:0] U_IDLE    = 1'b0;
  localparam logic [0:0] U_ACK     = 1'b1;

  // Synchronisers for the expander handshake inputs
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0] avail_sync_q, avail_sync_d;
  logic                   ack_n_s, avail_s;

  // Down direction (host -> meter)
  logic [7:0]    dn_mem [FIFO_DEPTH];
  logic [AW-1:0] dn_wr_ptr_q, dn_wr_ptr_d, dn_rd_ptr_q, dn_rd_ptr_d;
  logic [AW:0]   dn_cnt_q, dn_cnt_d;
  logic          dn_full, dn_empty, dn_push, dn_pop;
  logic [1:0]    d_state_q, d_state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_avail_q, tx_avail_d;

  // Up direction (meter -> host)
  logic [7:0]    up_mem [FIFO_DEPTH];
  logic [AW-1:0] up_wr_ptr_q, up_wr_ptr_d, up_rd_ptr_q, up_rd_ptr_d;
  logic [AW:0]   up_cnt_q, up_cnt_d;
  logic          up_full, up_empty, up_push, up_pop;
  logic [0:0]    u_state_q, u_state_d;

  // Shift each async input one stage further into the clk domain
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ack_sync_d      = ack_sync_q;
    avail_sync_d    = avail_sync_q;
    ack_sync_d[0]   = ib_tx_data_ack_n;
    avail_sync_d[0] = ib_rx_data_avail;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ack_sync_d[i]   = ack_sync_q[i-1];
      avail_sync_d[i] = avail_sync_q[i-1];
    end
  end

  assign ack_n_s = ack_sync_q[SYNC_STAGES-1];
  assign avail_s = avail_sync_q[SYNC_STAGES-1];

  assign dn_full         = (dn_cnt_q == FULL_CNT);
  assign dn_empty        = (dn_cnt_q == '0);
  assign dn_push         = uart_rx_valid && !dn_full;
  assign uart_rx_overrun = uart_rx_valid && dn_full;

  assign up_full       = (up_cnt_q == FULL_CNT);
  assign up_empty      = (up_cnt_q == '0);
  assign uart_tx_valid = !up_empty;
  // Gated so the unreset storage never shows through while the queue is empty.
  assign uart_tx_data  = up_empty ? 8'h00 : up_mem[up_rd_ptr_q];
  assign up_pop        = uart_tx_valid && uart_tx_ready;

  assign ib_tx_data       = tx_data_q;
  assign ib_tx_data_avail = tx_avail_q;
  assign ib_tx_ack        = (u_state_q == U_ACK);

  // Down FSM: offer the head byte, wait for ack, wait for ack release
  always_comb begin
    d_state_d  = d_state_q;
    tx_data_d  = tx_data_q;
    tx_avail_d = tx_avail_q;
    dn_pop     = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        // A low ack_n here is stale; hold off until the meter lets it go.
        if (!dn_empty && ack_n_s) begin
          tx_data_d  = dn_mem[dn_rd_ptr_q];
          tx_avail_d = 1'b1;
          dn_pop     = 1'b1;
          d_state_d  = D_OFFER;
        end
      end
      D_OFFER: begin
        if (!ack_n_s) begin
          tx_avail_d = 1'b0;
          d_state_d  = D_RELEASE;
        end
      end
      D_RELEASE: begin
        if (ack_n_s) d_state_d = D_IDLE;
      end
      default: begin
        tx_avail_d = 1'b0;
        d_state_d  = D_IDLE;
      end
    endcase
  end

  // Up FSM: take one meter byte per avail pulse, stall while the queue is full
  always_comb begin
    u_state_d = u_state_q;
    up_push   = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (avail_s && !up_full) begin
          up_push   = 1'b1;
          u_state_d = U_ACK;
        end
      end
      default: begin
        if (!avail_s) u_state_d = U_IDLE;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping for both queues
  always_comb begin
    dn_wr_ptr_d = dn_push ? dn_wr_ptr_q + PTR_ONE : dn_wr_ptr_q;
    dn_rd_ptr_d = dn_pop  ? dn_rd_ptr_q + PTR_ONE : dn_rd_ptr_q;
    dn_cnt_d    = dn_cnt_q;
    if (dn_push && !dn_pop)      dn_cnt_d = dn_cnt_q + CNT_ONE;
    else if (!dn_push && dn_pop) dn_cnt_d = dn_cnt_q - CNT_ONE;

    up_wr_ptr_d = up_push ? up_wr_ptr_q + PTR_ONE : up_wr_ptr_q;
    up_rd_ptr_d = up_pop  ? up_rd_ptr_q + PTR_ONE : up_rd_ptr_q;
    up_cnt_d    = up_cnt_q;
    if (up_push && !up_pop)      up_cnt_d = up_cnt_q + CNT_ONE;
    else if (!up_push && up_pop) up_cnt_d = up_cnt_q - CNT_ONE;
  end

  // Queue storage writes
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the occupancy counters alone define validity.
    if (dn_push) dn_mem[dn_wr_ptr_q] <= uart_rx_data;
    if (up_push) up_mem[up_wr_ptr_q] <= ib_rx_data;
  end

  // State registers; reset aborts both handshakes and empties both queues
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      ack_sync_q   <= '1;
      avail_sync_q <= '0;
      dn_wr_ptr_q  <= '0;
      dn_rd_ptr_q  <= '0;
      dn_cnt_q     <= '0;
      d_state_q    <= D_IDLE;
      tx_data_q    <= 8'h00;
      tx_avail_q   <= 1'b0;
      up_wr_ptr_q  <= '0;
      up_rd_ptr_q  <= '0;
      up_cnt_q     <= '0;
      u_state_q    <= U_IDLE;
    end else begin
      ack_sync_q   <= ack_sync_d;
      avail_sync_q <= avail_sync_d;
      dn_wr_ptr_q  <= dn_wr_ptr_d;
      dn_rd_ptr_q  <= dn_rd_ptr_d;
      dn_cnt_q     <= dn_cnt_d;
      d_state_q    <= d_state_d;
      tx_data_q    <= tx_data_d;
      tx_avail_q   <= tx_avail_d;
      up_wr_ptr_q  <= up_wr_ptr_d;
      up_rd_ptr_q  <= up_rd_ptr_d;
      up_cnt_q     <= up_cnt_d;
      u_state_q    <= u_state_d;
    end
  end

endmodule
